// File: rtl/game_pkg.sv
// Shared types and constants for the note-judging slice: lane width,
// per-lane and top-level state encodings, and the per-lane event bundle.
package game_pkg;

    localparam int LANE_W = 16;

    // Per-lane judge state: nothing at the judge row, a live note waiting
    // for a press, or a note already hit and waiting to scroll away.
    typedef enum logic [1:0] {
        LANE_IDLE  = 2'd0,
        LANE_ARMED = 2'd1,
        LANE_DONE  = 2'd2
    } lane_state_e;

    // Game-level state; OVER is only left through reset.
    typedef enum logic {
        TOP_PLAY = 1'b0,
        TOP_OVER = 1'b1
    } top_state_e;

    // Everything a lane reports to the scoring logic in one cycle.
    // pf is the point flag of the note currently at the judge row.
    typedef struct packed {
        logic hit;
        logic miss;
        logic stray;
        logic pf;
    } lane_event_t;

    // Score earned by one lane in one cycle: 1 per hit, plus the bonus
    // when the hit note carried a point marker.
    function automatic int unsigned note_points(input logic        hit,
                                                input logic        pf,
                                                input int unsigned bonus);
        if (!hit) begin
            return 0;
        end
        return pf ? (1 + bonus) : 1;
    endfunction

endpackage

// File: rtl/lane_judge.sv
// One judged lane: button synchroniser and rising-edge detect, plus the
// IDLE/ARMED/DONE state machine that turns presses and lane shifts into
// hit, miss and stray-press events.
module lane_judge
    import game_pkg::*;
#(
    parameter int HIT_ROW = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              shift,
    input  logic [LANE_W-1:0] line,
    input  logic [LANE_W-1:0] pnts,
    input  logic              btn,
    output lane_event_t       ev
);

    // The row just above the judge row becomes the judged note on a shift.
    localparam int NEXT_ROW = HIT_ROW + 1;

    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic        press;
    lane_state_e state_q;
    lane_state_e state_d;
    logic        pf_q;
    logic        pf_d;

    // Only the row feeding the judge row is observed; the rest of the
    // lane is consumed here so the whole bus is visibly accounted for.
    logic unused_lane_bits;
    assign unused_lane_bits = ^{line, pnts};

    // Two-flop synchroniser on the raw button, then a delayed copy for edge detect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so this chain really is three stages deep.
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A press is the single cycle where the synchronised level rises.
    assign press = sync2_q & ~prev_q;

    // Lane state and the latched point flag of the note at the judge row.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= LANE_IDLE;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pf_q    <= pf_d;
        end
    end

    // Judge the press against the outgoing note first, then apply the shift.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        pf_d     = pf_q;
        ev.hit   = 1'b0;
        ev.miss  = 1'b0;
        ev.stray = 1'b0;
        ev.pf    = pf_q;

        if (enable) begin
            if (press) begin
                if (state_q == LANE_ARMED) begin
                    ev.hit = 1'b1;
                end else begin
                    ev.stray = 1'b1;
                end
            end

            // An armed note leaving unhit is a miss; a same-cycle press saves it.
            if (shift && (state_q == LANE_ARMED) && !press) begin
                ev.miss = 1'b1;
            end

            // A shift always re-arms from the incoming row, even out of DONE.
            if (shift) begin
                state_d = line[NEXT_ROW] ? LANE_ARMED : LANE_IDLE;
                pf_d    = pnts[NEXT_ROW];
            end else if (ev.hit) begin
                state_d = LANE_DONE;
            end
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Consumer end of the note-lane interface: two lane judges feed a shared
// scorer that keeps score, combo and lives, and a PLAY/OVER game FSM.
module hit_judge
    import game_pkg::*;
#(
    parameter int          HIT_ROW    = 0,
    parameter int          SCORE_W    = 12,
    parameter int          COMBO_W    = 8,
    parameter int          LIVES_W    = 2,
    parameter int          LIVES_INIT = 3,
    parameter int unsigned PNT_BONUS  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SHIFT,
    input  logic [LANE_W-1:0]  LINE1,
    input  logic [LANE_W-1:0]  LINE2,
    input  logic [LANE_W-1:0]  PNTS1,
    input  logic [LANE_W-1:0]  PNTS2,
    input  logic               BTN1,
    input  logic               BTN2,
    output logic               HIT1,
    output logic               HIT2,
    output logic               MISS1,
    output logic               MISS2,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO,
    output logic [LIVES_W-1:0] LIVES,
    output logic               GAME_OVER
);

    top_state_e         state_q;
    top_state_e         state_d;
    logic               playing;
    lane_event_t        ev1;
    lane_event_t        ev2;

    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d;
    logic [1:0]         hit_cnt;
    logic [COMBO_W:0]   combo_sum;
    logic [COMBO_W-1:0] combo_d;
    logic [1:0]         miss_cnt;
    logic [LIVES_W+1:0] lives_ext;
    logic [LIVES_W+1:0] miss_ext;
    logic [LIVES_W-1:0] lives_d;

    logic               hit1_q;
    logic               hit2_q;
    logic               miss1_q;
    logic               miss2_q;
    logic [SCORE_W-1:0] score_q;
    logic [COMBO_W-1:0] combo_q;
    logic [LIVES_W-1:0] lives_q;

    // Lanes are frozen once the game is over, so they raise no events.
    assign playing = (state_q == TOP_PLAY);

    lane_judge #(
        .HIT_ROW (HIT_ROW)
    ) u_lane1 (
        .CLK    (CLK),
        .RST    (RST),
        .enable (playing),
        .shift  (SHIFT),
        .line   (LINE1),
        .pnts   (PNTS1),
        .btn    (BTN1),
        .ev     (ev1)
    );

    lane_judge #(
        .HIT_ROW (HIT_ROW)
    ) u_lane2 (
        .CLK    (CLK),
        .RST    (RST),
        .enable (playing),
        .shift  (SHIFT),
        .line   (LINE2),
        .pnts   (PNTS2),
        .btn    (BTN2),
        .ev     (ev2)
    );

    // Combine both lanes into next score, combo and lives values.
    always_comb begin
        score_sum = {1'b0, score_q}
                  + (SCORE_W+1)'(note_points(ev1.hit, ev1.pf, PNT_BONUS))
                  + (SCORE_W+1)'(note_points(ev2.hit, ev2.pf, PNT_BONUS));
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        hit_cnt   = {1'b0, ev1.hit} + {1'b0, ev2.hit};
        combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(hit_cnt);
        // A miss or stray press on either lane breaks the chain, even if
        // the other lane scored a hit in the same cycle.
        if (ev1.miss || ev2.miss || ev1.stray || ev2.stray) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        end

        miss_cnt  = {1'b0, ev1.miss} + {1'b0, ev2.miss};
        lives_ext = {2'b00, lives_q};
        miss_ext  = (LIVES_W+2)'(miss_cnt);
        lives_d   = (miss_ext >= lives_ext) ? '0 : LIVES_W'(lives_ext - miss_ext);
    end

    // Game state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= TOP_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter OVER on the edge where lives reach zero; stay until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TOP_PLAY: begin
                if (lives_d == '0) begin
                    state_d = TOP_OVER;
                end
            end
            TOP_OVER: begin
                state_d = TOP_OVER;
            end
            default: begin
                state_d = TOP_PLAY;
            end
        endcase
    end

    // Registered pulses and counters, all updated on the judging edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            miss1_q <= 1'b0;
            miss2_q <= 1'b0;
            score_q <= '0;
            combo_q <= '0;
            lives_q <= LIVES_W'(LIVES_INIT);
        end else begin
            hit1_q  <= ev1.hit;
            hit2_q  <= ev2.hit;
            miss1_q <= ev1.miss;
            miss2_q <= ev2.miss;
            if (playing) begin
                score_q <= score_d;
                combo_q <= combo_d;
                lives_q <= lives_d;
            end
        end
    end

    assign HIT1      = hit1_q;
    assign HIT2      = hit2_q;
    assign MISS1     = miss1_q;
    assign MISS2     = miss2_q;
    assign SCORE     = score_q;
    assign COMBO     = combo_q;
    assign LIVES     = lives_q;
    assign GAME_OVER = (state_q == TOP_OVER);

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios followed by
// randomized play, all compared against a behavioural game model.
module tb_hit_judge;

    localparam int HR   = 0;
    localparam int SW   = 12;
    localparam int CW   = 8;
    localparam int LW   = 2;
    localparam int LI   = 3;
    localparam int PB   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [15:0] ARM = 16'(1 << (HR + 1));

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          SHIFT = 1'b0;
    logic [15:0]   LINE1 = '0;
    logic [15:0]   LINE2 = '0;
    logic [15:0]   PNTS1 = '0;
    logic [15:0]   PNTS2 = '0;
    logic          BTN1 = 1'b0;
    logic          BTN2 = 1'b0;
    logic          HIT1, HIT2, MISS1, MISS2, GAME_OVER;
    logic [SW-1:0] SCORE;
    logic [CW-1:0] COMBO;
    logic [LW-1:0] LIVES;

    hit_judge #(
        .HIT_ROW(HR), .SCORE_W(SW), .COMBO_W(CW), .LIVES_W(LW),
        .LIVES_INIT(LI), .PNT_BONUS(PB)
    ) dut (
        .CLK(CLK), .RST(RST), .SHIFT(SHIFT),
        .LINE1(LINE1), .LINE2(LINE2), .PNTS1(PNTS1), .PNTS2(PNTS2),
        .BTN1(BTN1), .BTN2(BTN2),
        .HIT1(HIT1), .HIT2(HIT2), .MISS1(MISS1), .MISS2(MISS2),
        .SCORE(SCORE), .COMBO(COMBO), .LIVES(LIVES), .GAME_OVER(GAME_OVER)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: a pending note per lane, its point flag, the button
    // levels seen at recent edges, and the scoreboard values.
    int       m_score, m_combo, m_lives;
    bit       m_over;
    bit       m_armed [2];
    bit       m_pf    [2];
    bit [2:0] m_bh    [2];   // [0] = level at last edge, [1] = two edges ago, [2] = three
    bit       e_hit   [2];
    bit       e_miss  [2];
    bit       rb1, rb2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_lives = LI; m_over = 0;
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 0; m_pf[i] = 0; m_bh[i] = '0; e_hit[i] = 0; e_miss[i] = 0;
        end
    endtask

    // Predict the effect of the coming rising edge from the driven inputs.
    task automatic model_edge();
        logic [15:0] ln [2];
        logic [15:0] pt [2];
        bit          bt [2];
        int          add, hits, misses;
        bit          broke;
        ln[0] = LINE1; ln[1] = LINE2; pt[0] = PNTS1; pt[1] = PNTS2;
        bt[0] = BTN1;  bt[1] = BTN2;
        add = 0; hits = 0; misses = 0; broke = 0;
        for (int i = 0; i < 2; i++) begin
            // A raw rise seen at edge k is judged at edge k+2.
            bit press;
            press = m_bh[i][1] && !m_bh[i][2];
            e_hit[i] = 0; e_miss[i] = 0;
            if (!m_over) begin
                if (press && m_armed[i]) begin
                    e_hit[i] = 1; hits++; add += 1 + (m_pf[i] ? PB : 0);
                end else if (press) begin
                    broke = 1;
                end
                if (SHIFT && m_armed[i] && !press) begin
                    e_miss[i] = 1; misses++; broke = 1;
                end
                if (SHIFT) begin
                    m_armed[i] = ln[i][HR+1]; m_pf[i] = pt[i][HR+1];
                end else if (e_hit[i]) begin
                    m_armed[i] = 0;
                end
            end
            m_bh[i] = {m_bh[i][1:0], bt[i]};
        end
        if (!m_over) begin
            m_score = (m_score + add > SMAX) ? SMAX : m_score + add;
            m_combo = broke ? 0 : ((m_combo + hits > CMAX) ? CMAX : m_combo + hits);
            m_lives = (m_lives - misses < 0) ? 0 : m_lives - misses;
            if (m_lives == 0) m_over = 1;
        end
    endtask

    task automatic check_outputs();
        check("hit1", HIT1, e_hit[0]);
        check("hit2", HIT2, e_hit[1]);
        check("miss1", MISS1, e_miss[0]);
        check("miss2", MISS2, e_miss[1]);
        check("score", SCORE, m_score);
        check("combo", COMBO, m_combo);
        check("lives", LIVES, m_lives);
        check("game_over", GAME_OVER, m_over);
    endtask

    task automatic cycle(input bit sh, input logic [15:0] l1, input logic [15:0] l2,
                         input logic [15:0] p1, input logic [15:0] p2, input bit b1, input bit b2);
        SHIFT = sh; LINE1 = l1; LINE2 = l2; PNTS1 = p1; PNTS2 = p2; BTN1 = b1; BTN2 = b2;
        model_edge();
        @(posedge CLK); #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        RST = 1'b0; SHIFT = 0; LINE1 = '0; LINE2 = '0; PNTS1 = '0; PNTS2 = '0;
        BTN1 = 0; BTN2 = 0; rb1 = 0; rb2 = 0;
        #2;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        check("rst_score", SCORE, 0);
        check("rst_combo", COMBO, 0);
        check("rst_lives", LIVES, LI);
        check("rst_over", GAME_OVER, 0);
        check("rst_pulses", {HIT1, HIT2, MISS1, MISS2}, 0);
    endtask

    // Arm lane 1 (and lane 2 if two) on a shift and press on that same note.
    task automatic hit_note(input bit two, input bit bonus);
        cycle(1, ARM, two ? ARM : 16'h0, bonus ? ARM : 16'h0, (two && bonus) ? ARM : 16'h0, 1, two);
        idle(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and quiet lanes.
        do_reset();
        idle(20);

        // Single plain hit, pressed a few cycles after arming.
        cycle(1, ARM, '0, '0, '0, 0, 0);
        idle(3);
        for (int i = 0; i < 5; i++) cycle(0, '0, '0, '0, '0, 1, 0);
        idle(2);
        check("single_score", SCORE, 1);
        check("single_combo", COMBO, 1);

        // Double hit, lane 1 with a point marker: +6 in one cycle.
        cycle(1, ARM, ARM, ARM, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, '0, 1, 1);
        idle(2);
        check("double_score", SCORE, 7);
        check("double_combo", COMBO, 3);

        // Lane 2 note scrolls away unhit.
        cycle(1, '0, ARM, '0, '0, 0, 0);
        cycle(1, '0, '0, '0, '0, 0, 0);
        check("miss2_pulse", MISS2, 1);
        check("miss2_lives", LIVES, 2);
        check("miss2_combo", COMBO, 0);

        // Press landing in the shift cycle hits the outgoing note.
        cycle(1, '0, ARM, '0, '0, 0, 0);
        cycle(0, '0, '0, '0, '0, 0, 1);
        cycle(0, '0, '0, '0, '0, 0, 1);
        cycle(1, '0, '0, '0, '0, 0, 1);
        check("shift_hit2", HIT2, 1);
        check("shift_nomiss2", MISS2, 0);
        idle(2);
        check("shift_lives", LIVES, 2);
        check("shift_score", SCORE, 8);

        // Build combo to 5, then a stray press on a non-armed lane.
        for (int i = 0; i < 4; i++) hit_note(0, 0);
        check("combo5", COMBO, 5);
        for (int i = 0; i < 6; i++) cycle(0, '0, '0, '0, '0, 1, 0);
        check("stray_combo", COMBO, 0);
        check("stray_score", SCORE, 12);
        check("stray_lives", LIVES, 2);
        // Button still held while a note arms: no new press.
        cycle(1, ARM, '0, '0, '0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, '0, 0, 0);
        cycle(1, '0, '0, '0, '0, 0, 0);
        check("held_miss1", MISS1, 1);
        check("held_lives", LIVES, 1);
        check("held_score", SCORE, 12);

        // Reset with a note pending discards it silently.
        cycle(1, ARM, ARM, '0, '0, 0, 0);
        do_reset();
        cycle(1, '0, '0, '0, '0, 0, 0);
        check("rst_nomiss", {MISS1, MISS2}, 0);
        check("rst_mid_lives", LIVES, LI);

        // Score and combo saturation.
        while (m_score < SMAX - 5) hit_note(1, 1);
        check("combo_sat", COMBO, CMAX);
        hit_note(1, 1);
        check("score_clamp", SCORE, SMAX);

        // Three misses end the game; everything then freezes.
        cycle(1, ARM, '0, '0, '0, 0, 0);
        cycle(1, ARM, '0, '0, '0, 0, 0);
        cycle(1, ARM, '0, '0, '0, 0, 0);
        cycle(1, '0, '0, '0, '0, 0, 0);
        check("over_lives", LIVES, 0);
        check("over_flag", GAME_OVER, 1);
        for (int i = 0; i < 40; i++) begin
            rb1 = ($urandom_range(0, 2) == 0) ? !rb1 : rb1;
            rb2 = ($urandom_range(0, 2) == 0) ? !rb2 : rb2;
            cycle($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), rb1, rb2);
        end
        check("over_score_hold", SCORE, SMAX);
        check("over_combo_hold", COMBO, 0);
        check("over_flag_hold", GAME_OVER, 1);

        // Randomized play episodes with occasional resets.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 255) == 0) do_reset();
                rb1 = ($urandom_range(0, 2) == 0) ? !rb1 : rb1;
                rb2 = ($urandom_range(0, 2) == 0) ? !rb2 : rb2;
                cycle($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), rb1, rb2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Consumer end of the note-lane interface. Watches the two scrolling note lanes (LINE1/LINE2) and their point-marker lanes (PNTS1/PNTS2) at a fixed judge row.
- Compares the lanes with player button presses and produces hit/miss pulses, a score, a combo count, remaining lives and a game-over flag.
- Sits between the lane shifter and the display/score logic at top level.

Parameters:
- HIT_ROW, 0, lane bit index being judged; legal range 0..14.
- SCORE_W, 12, score width in bits; score saturates at all-ones.
- COMBO_W, 8, combo counter width; saturates at all-ones.
- LIVES_W, 2, lives counter width.
- LIVES_INIT, 3, lives loaded at reset.
- PNT_BONUS, 4, extra score for hitting a note whose point marker is set.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-low.
- SHIFT  in  1  strobe, high in the cycle whose rising edge shifts the lanes right by one; lane values seen in that cycle are pre-shift values.
- LINE1  in  16  lane 1 notes; bit 15 is the entry row.
- LINE2  in  16  lane 2 notes.
- PNTS1  in  16  lane 1 point markers, aligned with LINE1.
- PNTS2  in  16  lane 2 point markers, aligned with LINE2.
- BTN1  in  1  raw lane-1 button, asynchronous, active-high.
- BTN2  in  1  raw lane-2 button.
- HIT1  out  1  one-cycle pulse, lane-1 hit.
- HIT2  out  1  one-cycle pulse, lane-2 hit.
- MISS1  out  1  one-cycle pulse, lane-1 note left the judge row unhit.
- MISS2  out  1  one-cycle pulse, lane-2 miss.
- SCORE  out  SCORE_W  accumulated score.
- COMBO  out  COMBO_W  consecutive hits since the last miss or stray press.
- LIVES  out  LIVES_W  remaining lives.
- GAME_OVER  out  1  high once lives reach 0.

Behaviour:
- Reset (RST=0, async) values:
  - All pulses 0, SCORE 0, COMBO 0, LIVES=LIVES_INIT, GAME_OVER 0.
  - Both lane FSMs IDLE, top FSM PLAY, synchronisers cleared.
  - A note already present at HIT_ROW when reset releases is ignored.
- Buttons:
  - 2-FF synchroniser per button, then rising-edge detect. A press is a 1-cycle internal event, 3 CLK after the raw edge at worst.
  - Holding a button produces a single press.
- Lane FSM (per lane), states IDLE, ARMED, DONE; plus a latched point flag PF.
  - On SHIFT: if the state is ARMED, emit a miss for that lane. Next state is ARMED if LINE[HIT_ROW+1]=1, else IDLE. PF <= PNTS[HIT_ROW+1].
  - Press while ARMED: hit, state becomes DONE.
  - Press while IDLE or DONE: stray press. COMBO <= 0; no lives change; no pulse.
  - Press and SHIFT in the same cycle: the press is judged against the outgoing note first (a hit if ARMED, so no miss), then the SHIFT transition applies.
  - Back-to-back notes re-arm on each SHIFT, independent of DONE.
- Scoring, evaluated per cycle with both lanes combined:
  - Each hit adds 1, plus PNT_BONUS if PF=1.
  - A double hit adds both sums in the same cycle.
  - The addition is done at SCORE_W+1 bits and clamped to all-ones.
  - COMBO increments by the hit count (1 or 2), saturating.
  - Any miss sets COMBO to 0. A miss takes precedence over a same-cycle hit on the other lane for the combo; the score still adds.
  - Each miss decrements LIVES by 1, clamped at 0; a double miss subtracts 2.
- Outputs:
  - HIT/MISS pulses are registered and assert the cycle after the judging edge.
  - SCORE, COMBO and LIVES update on that same edge.
- Top FSM, states PLAY and OVER:
  - PLAY to OVER when LIVES becomes 0; GAME_OVER=1 from that edge.
  - In OVER: ignore presses and SHIFT; no pulses; SCORE, COMBO and LIVES hold.
  - Leave OVER only through reset.
- Reset mid-note: any pending ARMED note is discarded; no miss is emitted.

Decomposition:
- Shared package (game_pkg): lane-state encoding (IDLE/ARMED/DONE), top-state encoding (PLAY/OVER), LANE_W=16.
- One sub-module, lane_judge: synchroniser, edge detect and lane FSM, instantiated once per lane. It outputs hit, miss and PF.
- hit_judge holds the scoring, lives and top FSM.

Test Plan:
- Reset with LIVES_INIT=3 -> SCORE=0, COMBO=0, LIVES=3, GAME_OVER=0, no pulses for 20 cycles with idle lanes.
- LINE1[1]=1, PNTS1[1]=0, SHIFT, then BTN1 rising 4 cycles later -> single HIT1 pulse, SCORE=1, COMBO=1.
- Same setup but PNTS1[1]=1, and BTN1/BTN2 pressed together on two armed notes with PNTS2=0 -> SCORE += 5+1 = 6 in one cycle, COMBO += 2.
- Armed lane-2 note with no press, next SHIFT -> MISS2 pulse, LIVES 3->2, COMBO=0; press during the same SHIFT cycle instead -> HIT2, no MISS2.
- Press on an IDLE lane with COMBO=5 -> COMBO=0, SCORE and LIVES unchanged; a held button gives one press only.
- Three consecutive misses -> LIVES=0, GAME_OVER=1. Further presses/SHIFTs change nothing. SCORE near all-ones (4094) plus a bonus hit -> clamps at 4095.
